btn_debounce_multi: RTL and testbench



---
 rtl/btn_debounce_multi.sv | 120 ++++++++++++
 tb/tb_btn_debounce_multi.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_multi.sv
// N-channel button debouncer: 2-flop sync, stability filter, press/release/long-press pulses.
// Optional auto-repeat of press_pulse after long_press: define BTN_DEBOUNCE_MULTI_AUTO_REPEAT_EN.
module btn_debounce_multi #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned STABLE_CYCLES = 1048575,
    parameter int unsigned HOLD_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_press
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [SW-1:0] StableMax = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HoldMax   = HW'(HOLD_CYCLES);

    logic [N_CH-1:0] sync1_q, sync2_q;
    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] press_q, press_d;
    logic [N_CH-1:0] release_q, release_d;
    logic [N_CH-1:0] long_q, long_d;
    logic [N_CH-1:0] done_q, done_d;
    logic [SW-1:0]   stable_q [N_CH];
    logic [SW-1:0]   stable_d [N_CH];
    logic [HW-1:0]   hold_q   [N_CH];
    logic [HW-1:0]   hold_d   [N_CH];

`ifdef BTN_DEBOUNCE_MULTI_AUTO_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] RepeatMax = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_q [N_CH];
    logic [RW-1:0] rep_d [N_CH];
`endif

    always_comb begin
        for (int i = 0; i < int'(N_CH); i++) begin
            level_d[i]  = level_q[i];
            stable_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (stable_q[i] == StableMax) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    stable_d[i] = stable_q[i] + 1'b1;
                end
            end
            press_d[i]   = level_d[i] & ~level_q[i];
            release_d[i] = ~level_d[i] & level_q[i];

            // Hold time counts only across edges where the level stays high.
            hold_d[i] = '0;
            done_d[i] = 1'b0;
            long_d[i] = 1'b0;
            if (level_q[i] && level_d[i]) begin
                hold_d[i] = (hold_q[i] == HoldMax) ? hold_q[i] : hold_q[i] + 1'b1;
                done_d[i] = done_q[i];
                if ((hold_d[i] == HoldMax) && !done_q[i]) begin
                    long_d[i] = 1'b1;
                    done_d[i] = 1'b1;
                end
            end

`ifdef BTN_DEBOUNCE_MULTI_AUTO_REPEAT_EN
            rep_d[i] = '0;
            if (done_q[i] && level_q[i] && level_d[i]) begin
                if (rep_q[i] == RepeatMax) begin
                    press_d[i] = 1'b1;
                end else begin
                    rep_d[i] = rep_q[i] + 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            done_q    <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                stable_q[i] <= '0;
                hold_q[i]   <= '0;
`ifdef BTN_DEBOUNCE_MULTI_AUTO_REPEAT_EN
                rep_q[i]    <= '0;
`endif
            end
        end else begin
            sync1_q   <= btn_in;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            done_q    <= done_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                stable_q[i] <= stable_d[i];
                hold_q[i]   <= hold_d[i];
`ifdef BTN_DEBOUNCE_MULTI_AUTO_REPEAT_EN
                rep_q[i]    <= rep_d[i];
`endif
            end
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: fixed vector table, timestamp-based reference model
// under random stimulus, and directed long-press / simultaneous-press sequences.
module tb_btn_debounce_multi;

    localparam int N = 4;
    localparam int S = 4;
    localparam int H = 16;
    localparam int R = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_in = '1;
    logic [N-1:0] btn_level, press_pulse, release_pulse, long_press;

    always #5 clk = ~clk;

    btn_debounce_multi #(
        .N_CH         (N),
        .STABLE_CYCLES(S),
        .HOLD_CYCLES  (H),
        .REPEAT_CYCLES(R)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press)
    );

    int total = 0;
    int bad   = 0;
    int t     = 0;

    // Reference model: s is btn_in delayed two edges (flushed by reset); the level
    // flips once s has disagreed with it for S edges since the last agreement.
    logic [N-1:0] in_m1 = '0, in_m2 = '0;
    logic         rst_m1 = 1'b1, rst_m2 = 1'b1;
    logic [N-1:0] m_level = '0;
    int           m_agree [N];
    int           m_rise  [N];
    logic [N-1:0] e_press, e_rel, e_long;

    typedef struct {
        logic       r;
        logic [3:0] b;
        logic [3:0] lvl;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] lp;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] b, input logic [3:0] lvl,
                       input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] lp,
                       input int n);
        vec_t v;
        v.r = r; v.b = b; v.lvl = lvl; v.pr = pr; v.rl = rl; v.lp = lp;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic model_edge(input logic [N-1:0] b, input logic r);
        logic [N-1:0] s;
        logic         prev;
        int           d;
        s       = (rst_m1 | rst_m2) ? '0 : in_m2;
        e_press = '0;
        e_rel   = '0;
        e_long  = '0;
        for (int c = 0; c < N; c++) begin
            if (r) begin
                m_level[c] = 1'b0;
                m_agree[c] = t;
            end else begin
                prev = m_level[c];
                if (s[c] == prev) begin
                    m_agree[c] = t;
                end else if (t - m_agree[c] == S) begin
                    m_level[c] = ~prev;
                    m_agree[c] = t;
                    if (!prev) begin
                        e_press[c] = 1'b1;
                        m_rise[c]  = t;
                    end else begin
                        e_rel[c] = 1'b1;
                    end
                end
                if (prev && m_level[c]) begin
                    d = t - m_rise[c];
                    if (d == H) e_long[c] = 1'b1;
`ifdef BTN_DEBOUNCE_MULTI_AUTO_REPEAT_EN
                    if (d > H && ((d - H) % R) == 0) e_press[c] = 1'b1;
`endif
                end
            end
        end
        in_m2  = in_m1;
        in_m1  = b;
        rst_m2 = rst_m1;
        rst_m1 = r;
    endtask

    task automatic cyc(input logic [N-1:0] b, input logic r);
        @(negedge clk);
        btn_in = b;
        rst    = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
        check("mdl_level", btn_level, m_level);
        check("mdl_press", press_pulse, e_press);
        check("mdl_release", release_pulse, e_rel);
        check("mdl_long", long_press, e_long);
        t++;
    endtask

    logic [N-1:0] cur;
    int           rem [N];
    int           rise_i, fall_i, long_n, long_i, cnt_a, cnt_b, cnt_c;
    int           press_at[$];

    initial begin
        for (int c = 0; c < N; c++) begin
            m_agree[c] = 0;
            m_rise[c]  = 0;
        end

        // Reset with all buttons held, fresh press, release, ch0 glitch, ch1 clean press.
        add(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 3);
        add(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 5);
        add(1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 1);
        add(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1);
        add(1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 5);
        add(1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1);
        add(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        add(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 3);
        add(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4);
        add(1'b0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 5);
        add(1'b0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 1);
        add(1'b0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4);
        add(1'b0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 5);
        add(1'b0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 1);
        add(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2);

        foreach (vecs[i]) begin
            cyc(vecs[i].b, vecs[i].r);
            check("tab_level", btn_level, vecs[i].lvl);
            check("tab_press", press_pulse, vecs[i].pr);
            check("tab_release", release_pulse, vecs[i].rl);
            check("tab_long", long_press, vecs[i].lp);
        end

        // Random held levels of varied length with occasional mid-run resets.
        cur = '0;
        for (int c = 0; c < N; c++) rem[c] = 1;
        for (int k = 0; k < 900; k++) begin
            for (int c = 0; c < N; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    cur[c] = $urandom_range(0, 1);
                    rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                         : $urandom_range(3, 45);
                end
            end
            cyc(cur, ($urandom_range(0, 99) == 0));
        end

        // Long press on ch2: 40-cycle hold.
        cyc('0, 1'b1);
        cyc('0, 1'b1);
        for (int k = 0; k < 8; k++) cyc('0, 1'b0);
        rise_i = -1; fall_i = -1; long_n = 0; long_i = -1;
        press_at.delete();
        for (int i = 0; i < 55; i++) begin
            cyc((i < 40) ? 4'b0100 : 4'b0000, 1'b0);
            if (btn_level[2] && rise_i < 0) rise_i = i;
            if (!btn_level[2] && rise_i >= 0 && fall_i < 0) fall_i = i;
            if (long_press[2]) begin
                long_n++;
                long_i = i;
            end
            if (press_pulse[2]) press_at.push_back(i);
        end
        check_int("lp_rise_edge", rise_i, 5);
        check_int("lp_fall_edge", fall_i, 45);
        check_int("lp_count", long_n, 1);
        check_int("lp_delay", long_i - rise_i, H);
`ifdef BTN_DEBOUNCE_MULTI_AUTO_REPEAT_EN
        check_int("rep_count", press_at.size(), 3);
        if (press_at.size() >= 3) begin
            check_int("rep_first", press_at[1] - long_i, R);
            check_int("rep_second", press_at[2] - long_i, 2 * R);
        end
`else
        check_int("press_count", press_at.size(), 1);
`endif
        if (press_at.size() >= 1) check_int("press_at_rise", press_at[0], rise_i);

        // Short 10-cycle hold: press and release but no long_press.
        long_n = 0; cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 30; i++) begin
            cyc((i < 10) ? 4'b0100 : 4'b0000, 1'b0);
            if (long_press[2]) long_n++;
            if (press_pulse[2]) cnt_a++;
            if (release_pulse[2]) cnt_b++;
        end
        check_int("short_long", long_n, 0);
        check_int("short_press", cnt_a, 1);
        check_int("short_release", cnt_b, 1);

        // ch0 and ch3 rise together while ch1 toggles every cycle.
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < 30; i++) begin
            cur = '0;
            if (i < 20) begin
                cur[0] = 1'b1;
                cur[3] = 1'b1;
                cur[1] = i[0];
            end
            cyc(cur, 1'b0);
            if (press_pulse == 4'b1001) cnt_a++;
            if (press_pulse != 4'b0000) cnt_b++;
            if (press_pulse[1] || release_pulse[1] || btn_level[1]) cnt_c++;
        end
        check_int("sim_press_1001", cnt_a, 1);
        check_int("sim_press_any", cnt_b, 1);
        check_int("sim_ch1_quiet", cnt_c, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
